// File: rtl/bcd_to_signed_binary.sv
// Signed BCD (sign + packed decimal digits) to two's-complement converter.
// Reverse double-dabble, one shift per clock, valid/ready on both sides.
module bcd_to_signed_binary #(
    parameter int DIGITS = 2,
    parameter int OUT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*DIGITS:0]  bcd_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   bin_out,
    output logic               err,
    output logic               ovf,
    output logic [1:0]         dbg_state
);

    // Handshake: a word moves on any rising edge where valid and ready are both high;
    // bin_out/err/ovf are held stable while out_valid is high and out_ready is low.

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(BW + 1);
    localparam int CW    = ((BW > OUT_W) ? BW : OUT_W) + 1;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BW - 1);
    localparam logic [CW-1:0] POS_MAX = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [CW-1:0] NEG_LIM = POS_MAX + CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIX   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_sign;
    logic               r_bad;
    logic [BW-1:0]      r_bcd;
    logic [BW-1:0]      r_mag;
    logic [CNT_W-1:0]   r_cnt;
    logic [OUT_W-1:0]   r_bin;
    logic               r_err;
    logic               r_ovf;

    logic               w_bad_digit;
    logic [2*BW-1:0]    w_cat;
    logic [BW-1:0]      w_bcd_adj;
    logic [CW-1:0]      w_mag_ext;
    logic [CW-1:0]      w_neg;
    logic [OUT_W-1:0]   w_bin;
    logic               w_ovf;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == LAST_SHIFT) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        dbg_state = r_state;
    end

    always_comb begin
        w_bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) w_bad_digit = 1'b1;
        end
    end

    // One reverse double-dabble step: shift the pair right, then correct digits >= 8.
    always_comb begin
        w_cat     = {r_bcd, r_mag} >> 1;
        w_bcd_adj = w_cat[2*BW-1:BW];
        for (int k = 0; k < DIGITS; k++) begin
            if (w_cat[BW + 4*k +: 4] >= 4'd8) begin
                w_bcd_adj[4*k +: 4] = w_cat[BW + 4*k +: 4] - 4'd3;
            end
        end
    end

    // Result shaping in a widened domain so the saturation compares never wrap.
    always_comb begin
        w_mag_ext = CW'(r_mag);
        w_neg     = CW'(0) - w_mag_ext;
        w_bin     = '0;
        w_ovf     = 1'b0;
        if (r_bad || (w_mag_ext == '0)) begin
            w_bin = '0;
        end else if (!r_sign) begin
            if (w_mag_ext > POS_MAX) begin
                w_ovf = 1'b1;
                w_bin = {1'b0, {(OUT_W-1){1'b1}}};
            end else begin
                w_bin = w_mag_ext[OUT_W-1:0];
            end
        end else begin
            if (w_mag_ext > NEG_LIM) begin
                w_ovf = 1'b1;
                w_bin = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                w_bin = w_neg[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_bad  <= 1'b0;
            r_bcd  <= '0;
            r_mag  <= '0;
            r_cnt  <= '0;
            r_bin  <= '0;
            r_err  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sign <= bcd_in[BW];
                        r_bcd  <= bcd_in[BW-1:0];
                        r_mag  <= '0;
                        r_cnt  <= '0;
                        r_bad  <= w_bad_digit;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_mag <= w_cat[BW-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FIX: begin
                    r_bin <= w_bin;
                    r_err <= r_bad;
                    r_ovf <= w_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign bin_out = r_bin;
    assign err     = r_err;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_bcd_to_signed_binary.sv
// Bench for bcd_to_signed_binary: an OUT_W=8 and an OUT_W=7 instance driven in lockstep,
// checked against a decimal-arithmetic reference model.
module tb_bcd_to_signed_binary;

    localparam int D = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic [4*D:0]   bcd_in = '0;

    logic           in_ready8, out_valid8, err8, ovf8;
    logic [7:0]     bin8;
    logic [1:0]     dbg8;
    logic           in_ready7, out_valid7, err7, ovf7;
    logic [6:0]     bin7;
    logic [1:0]     dbg7;

    int n_checks = 0;
    int n_errors = 0;

    bcd_to_signed_binary #(.DIGITS(D), .OUT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .bcd_in(bcd_in), .out_valid(out_valid8), .out_ready(out_ready),
        .bin_out(bin8), .err(err8), .ovf(ovf8), .dbg_state(dbg8)
    );

    bcd_to_signed_binary #(.DIGITS(D), .OUT_W(7)) u_dut7 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready7),
        .bcd_in(bcd_in), .out_valid(out_valid7), .out_ready(out_ready),
        .bin_out(bin7), .err(err7), .ovf(ovf7), .dbg_state(dbg7)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decimal value, then clamp to the signed range of ow bits.
    function automatic void model(input logic [4*D:0] w, input int ow,
                                  output logic [31:0] eb, output logic ee, output logic eo);
        int mag, v, scale, lim;
        logic [3:0] dig;
        ee = 1'b0; eo = 1'b0; mag = 0; scale = 1;
        for (int k = 0; k < D; k++) begin
            dig = w[4*k +: 4];
            if (dig > 9) ee = 1'b1;
            mag += int'(dig) * scale;
            scale *= 10;
        end
        lim = 1 << (ow - 1);
        if (ee) v = 0;
        else if (w[4*D]) begin
            if (mag > lim) begin v = -lim; eo = 1'b1; end
            else v = -mag;
        end else begin
            if (mag > lim - 1) begin v = lim - 1; eo = 1'b1; end
            else v = mag;
        end
        eb = 32'(v) & ((32'd1 << ow) - 32'd1);
    endfunction

    task automatic run_word(input logic [4*D:0] w, input int hold);
        logic [31:0] eb8, eb7;
        logic ee8, eo8, ee7, eo7;
        int lat;
        model(w, 8, eb8, ee8, eo8);
        model(w, 7, eb7, ee7, eo7);
        lat = 0;
        while (!in_ready8 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("ready_before", 32'(in_ready8), 32'd1);
        out_ready = (hold == 0);
        in_valid = 1'b1;
        bcd_in = w;
        @(posedge clk); #1;
        in_valid = 1'b0;
        bcd_in = 9'($urandom);
        check("busy_after_accept", 32'(in_ready8), 32'd0);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", 32'(lat), 32'd9);
        check("valid7", 32'(out_valid7), 32'd1);
        check("bin8", 32'(bin8), eb8);
        check("err8", 32'(err8), 32'(ee8));
        check("ovf8", 32'(ovf8), 32'(eo8));
        check("bin7", 32'(bin7), eb7);
        check("err7", 32'(err7), 32'(ee7));
        check("ovf7", 32'(ovf7), 32'(eo7));
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            bcd_in = 9'($urandom);
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid8), 32'd1);
            check("hold_bin8", 32'(bin8), eb8);
            check("hold_bin7", 32'(bin7), eb7);
            check("hold_flags8", {30'd0, err8, ovf8}, {30'd0, ee8, eo8});
            check("hold_ready", 32'(in_ready8), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_valid", 32'(out_valid8), 32'd0);
        check("post_ready", 32'(in_ready8), 32'd1);
    endtask

    initial begin
        logic [4*D:0] w;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", 32'(in_ready8), 32'd1);
        check("rst_valid", 32'(out_valid8), 32'd0);
        check("rst_bin", 32'(bin8), 32'd0);
        check("rst_flags", {30'd0, err8, ovf8}, 32'd0);

        run_word(9'h0_57, 0);
        run_word(9'h1_42, 0);
        run_word(9'h1_99, 0);
        run_word(9'h1_00, 0);
        run_word(9'h0_99, 0);
        run_word(9'h1_64, 0);
        run_word(9'h1_28, 2);
        run_word(9'h0_57, 5);
        run_word(9'h0_3A, 0);

        // Abort a conversion on its fourth shift edge.
        in_valid = 1'b1;
        bcd_in = 9'h1_87;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", 32'(in_ready8), 32'd1);
        check("abort_valid", 32'(out_valid8), 32'd0);
        check("abort_bin", 32'(bin8), 32'd0);
        check("abort_err", 32'(err8), 32'd0);
        check("abort_state", 32'(dbg8), 32'd0);
        run_word(9'h0_12, 0);

        for (int i = 0; i < 40; i++) begin
            w[4*D] = 1'($urandom_range(0, 1));
            for (int k = 0; k < D; k++) begin
                w[4*k +: 4] = 4'($urandom_range(0, 11));
            end
            run_word(w, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
